// File: rtl/cpu_int_pkg.sv
// Shared definitions for the interrupt scheduler.
//   int_state_e : scheduler FSM encoding (idle / request outstanding)
//   SRC_W       : width of the source index presented on out_src
//   VEC_*_DEF   : default ISR vector table placement
package cpu_int_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } int_state_e;

  localparam int          SRC_W          = 2;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0040;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational lowest-set-bit priority encoder.
//   req_vec : request bits, bit 0 has the highest priority
//   idx     : index of the lowest set bit (0 when none set)
//   vld     : at least one bit of req_vec is set
module int_prio_enc #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_vec,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_sched_ctrl.sv
// Interrupt scheduler for the single-cycle CPU.
// Captures rising edges on the interrupt lines into pending bits, qualifies
// them with a software mask, and raises a request for the highest-priority
// eligible source that outranks everything currently in service. The request
// is held with a frozen source index until the pipeline acknowledges it; ERET
// retires the innermost in-service level.
//   in_clk, in_rst_n   : clock, asynchronous active-low reset
//   in_irq             : raw interrupt lines (synchronous to in_clk)
//   in_mask_we/_wdata  : mask register write port (1 = enabled)
//   in_ack             : pipeline takes the interrupt this cycle
//   in_eret            : ERET retiring this cycle
//   out_int_req        : interrupt request to the PC mux
//   out_vector         : ISR entry address for out_src
//   out_src            : requested source index
//   out_pending        : pending bits
//   out_in_service     : in-service bits
//   out_mask           : current mask
module int_sched_ctrl
  import cpu_int_pkg::*;
#(
  parameter int          N_SRC      = 3,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic [N_SRC-1:0] in_irq,
  input  logic             in_mask_we,
  input  logic [N_SRC-1:0] in_mask_wdata,
  input  logic             in_ack,
  input  logic             in_eret,
  output logic             out_int_req,
  output logic [31:0]      out_vector,
  output logic [SRC_W-1:0] out_src,
  output logic [N_SRC-1:0] out_pending,
  output logic [N_SRC-1:0] out_in_service,
  output logic [N_SRC-1:0] out_mask
);

  int_state_e       state, state_nxt;
  logic             load_req;
  logic [SRC_W-1:0] req_idx;

  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] in_service;
  logic [N_SRC-1:0] mask;

  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] ack_vec;
  logic [N_SRC-1:0] eret_vec;
  logic [N_SRC-1:0] pending_nxt;
  logic [N_SRC-1:0] in_service_nxt;

  logic [SRC_W-1:0] cand_idx;
  logic             cand_vld;
  logic [SRC_W-1:0] lvl_idx;
  logic             lvl_vld;
  logic             cand_take;
  logic             take;

  assign set_vec = in_irq & ~irq_prev;
  assign elig    = pending & mask;

  int_prio_enc #(.N(N_SRC), .IDX_W(SRC_W)) u_cand_enc (
    .req_vec (elig),
    .idx     (cand_idx),
    .vld     (cand_vld)
  );

  int_prio_enc #(.N(N_SRC), .IDX_W(SRC_W)) u_lvl_enc (
    .req_vec (in_service),
    .idx     (lvl_idx),
    .vld     (lvl_vld)
  );

  // No in-service bit means the current level is N_SRC, so any eligible
  // source qualifies; otherwise only a strictly higher priority preempts.
  assign cand_take = cand_vld && (!lvl_vld || (cand_idx < lvl_idx));
  assign take      = (state == ST_REQ) && in_ack;

  assign ack_vec  = take ? (N_SRC'(1) << req_idx) : '0;
  assign eret_vec = (in_eret && lvl_vld) ? (N_SRC'(1) << lvl_idx) : '0;

  // A new edge on the acknowledged source wins over the acceptance clear.
  assign pending_nxt    = (pending & ~ack_vec) | set_vec;
  // ERET clears the current level first, then the acknowledged level is set.
  assign in_service_nxt = (in_service & ~eret_vec) | ack_vec;

  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cand_take) begin
          state_nxt = ST_REQ;
          load_req  = 1'b1;
        end
      end
      ST_REQ: begin
        if (in_ack) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state      <= ST_IDLE;
      req_idx    <= '0;
      irq_prev   <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= '0;
    end else begin
      state      <= state_nxt;
      irq_prev   <= in_irq;
      pending    <= pending_nxt;
      in_service <= in_service_nxt;
      if (in_mask_we) begin
        mask <= in_mask_wdata;
      end
      if (load_req) begin
        req_idx <= cand_idx;
      end
    end
  end

  // req_idx only changes on entry to REQ, which keeps the vector stable
  // for the whole request.
  assign out_int_req    = (state == ST_REQ);
  assign out_src        = req_idx;
  assign out_vector     = VEC_BASE + (32'(req_idx) * VEC_STRIDE);
  assign out_pending    = pending;
  assign out_in_service = in_service;
  assign out_mask       = mask;

endmodule

// File: tb/tb_int_sched_ctrl.sv
module tb_int_sched_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  irq;
  logic        mask_we;
  logic [2:0]  mask_wdata;
  logic        ack;
  logic        eret;
  logic        int_req;
  logic [31:0] vector;
  logic [1:0]  src;
  logic [2:0]  pending;
  logic [2:0]  in_service;
  logic [2:0]  mask;

  int checks = 0;
  int errors = 0;

  int_sched_ctrl #(
    .N_SRC      (3),
    .VEC_BASE   (32'h0000_0100),
    .VEC_STRIDE (32'h0000_0040)
  ) dut (
    .in_clk         (clk),
    .in_rst_n       (rst_n),
    .in_irq         (irq),
    .in_mask_we     (mask_we),
    .in_mask_wdata  (mask_wdata),
    .in_ack         (ack),
    .in_eret        (eret),
    .out_int_req    (int_req),
    .out_vector     (vector),
    .out_src        (src),
    .out_pending    (pending),
    .out_in_service (in_service),
    .out_mask       (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [2:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic pulse_irq(input logic [2:0] v);
    irq = v;
    tick();
    irq = 3'b000;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    irq        = 3'b000;
    mask_we    = 1'b0;
    mask_wdata = 3'b000;
    ack        = 1'b0;
    eret       = 1'b0;
    #12;
    check("rst_req",     {31'd0, int_req}, 32'd0);
    check("rst_src",     {30'd0, src}, 32'd0);
    check("rst_vector",  vector, 32'h100);
    check("rst_pending", {29'd0, pending}, 32'd0);
    check("rst_insvc",   {29'd0, in_service}, 32'd0);
    check("rst_mask",    {29'd0, mask}, 32'd0);
    rst_n = 1'b1;

    // Basic request / acknowledge on source 1
    write_mask(3'b111);
    check("mask_111", {29'd0, mask}, 32'h7);
    pulse_irq(3'b010);
    check("s1_pending", {29'd0, pending}, 32'h2);
    check("s1_noreq_yet", {31'd0, int_req}, 32'd0);
    tick();
    check("s1_req",    {31'd0, int_req}, 32'd1);
    check("s1_src",    {30'd0, src}, 32'd1);
    check("s1_vector", vector, 32'h140);
    do_ack();
    check("s1_insvc",   {29'd0, in_service}, 32'h2);
    check("s1_pend_clr", {29'd0, pending}, 32'd0);
    check("s1_req_drop", {31'd0, int_req}, 32'd0);
    do_eret();
    check("s1_eret", {29'd0, in_service}, 32'd0);

    // Masking: source 1 held pending while disabled
    write_mask(3'b101);
    pulse_irq(3'b110);
    check("s2_pending", {29'd0, pending}, 32'h6);
    tick();
    check("s2_req",    {31'd0, int_req}, 32'd1);
    check("s2_src",    {30'd0, src}, 32'd2);
    check("s2_vector", vector, 32'h180);
    do_ack();
    check("s2_insvc",  {29'd0, in_service}, 32'h4);
    check("s2_pend1",  {29'd0, pending}, 32'h2);
    tick();
    check("s2_masked_noreq", {31'd0, int_req}, 32'd0);
    do_eret();
    check("s2_eret", {29'd0, in_service}, 32'd0);
    write_mask(3'b111);
    check("s2_mask_delay", {31'd0, int_req}, 32'd0);
    tick();
    check("s2_unmask_req", {31'd0, int_req}, 32'd1);
    check("s2_unmask_src", {30'd0, src}, 32'd1);
    do_ack();
    check("s2_insvc1", {29'd0, in_service}, 32'h2);
    do_eret();

    // Nesting: source 0 preempts source 2
    pulse_irq(3'b100);
    tick();
    check("n_req2", {30'd0, src}, 32'd2);
    do_ack();
    check("n_insvc_100", {29'd0, in_service}, 32'h4);
    pulse_irq(3'b001);
    tick();
    check("n_req0",    {31'd0, int_req}, 32'd1);
    check("n_src0",    {30'd0, src}, 32'd0);
    check("n_vector0", vector, 32'h100);
    do_ack();
    check("n_insvc_101", {29'd0, in_service}, 32'h5);
    do_eret();
    check("n_eret1", {29'd0, in_service}, 32'h4);
    do_eret();
    check("n_eret2", {29'd0, in_service}, 32'd0);

    // No preemption at equal or lower priority
    pulse_irq(3'b001);
    tick();
    do_ack();
    check("np_insvc", {29'd0, in_service}, 32'h1);
    pulse_irq(3'b011);
    check("np_pending", {29'd0, pending}, 32'h3);
    tick();
    check("np_blocked_a", {31'd0, int_req}, 32'd0);
    tick();
    check("np_blocked_b", {31'd0, int_req}, 32'd0);
    do_eret();
    check("np_eret", {29'd0, in_service}, 32'd0);
    check("np_not_yet", {31'd0, int_req}, 32'd0);
    tick();
    check("np_req",  {31'd0, int_req}, 32'd1);
    check("np_src0", {30'd0, src}, 32'd0);
    do_ack();
    check("np_pend1", {29'd0, pending}, 32'h2);
    tick();
    check("np_src1_blocked", {31'd0, int_req}, 32'd0);
    do_eret();
    tick();
    check("np_req1", {31'd0, int_req}, 32'd1);
    check("np_src1", {30'd0, src}, 32'd1);
    do_ack();
    do_eret();

    // Ack coinciding with a new edge on the same source, then ERET+ack
    pulse_irq(3'b100);
    tick();
    check("ae_req2", {30'd0, src}, 32'd2);
    irq = 3'b100;
    ack = 1'b1;
    tick();
    irq = 3'b000;
    ack = 1'b0;
    check("ae_pend_kept", {29'd0, pending}, 32'h4);
    check("ae_insvc",     {29'd0, in_service}, 32'h4);
    check("ae_idle",      {31'd0, int_req}, 32'd0);
    pulse_irq(3'b001);
    tick();
    check("ae_req0", {30'd0, src}, 32'd0);
    ack  = 1'b1;
    eret = 1'b1;
    tick();
    ack  = 1'b0;
    eret = 1'b0;
    check("ae_eret_ack", {29'd0, in_service}, 32'h1);
    do_eret();
    check("ae_eret0", {29'd0, in_service}, 32'd0);
    tick();
    check("ae_second_req", {31'd0, int_req}, 32'd1);
    check("ae_second_src", {30'd0, src}, 32'd2);
    do_ack();
    do_eret();

    // Frozen request, then asynchronous reset mid-request
    pulse_irq(3'b010);
    tick();
    check("fz_req", {30'd0, src}, 32'd1);
    irq = 3'b001;
    write_mask(3'b000);
    irq = 3'b000;
    check("fz_still_req", {31'd0, int_req}, 32'd1);
    check("fz_src",       {30'd0, src}, 32'd1);
    check("fz_pending",   {29'd0, pending}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_req",     {31'd0, int_req}, 32'd0);
    check("ar_pending", {29'd0, pending}, 32'd0);
    check("ar_insvc",   {29'd0, in_service}, 32'd0);
    check("ar_mask",    {29'd0, mask}, 32'd0);
    check("ar_vector",  vector, 32'h100);
    #3;
    rst_n = 1'b1;
    do_ack();
    check("idle_ack_insvc", {29'd0, in_service}, 32'd0);
    check("idle_ack_req",   {31'd0, int_req}, 32'd0);
    check("idle_ack_pend",  {29'd0, pending}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
